// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register for the ARM core: captures decoded controls and operands,
// with freeze (stall), flush (bubble) and synchronous reset.
module id_exe_stage_reg #(
  parameter int WORD_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int CMD_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [WORD_W-1:0]     pc_in,
  input  logic [CMD_W-1:0]      exe_cmd_in,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic                  b_in,
  input  logic                  s_in,
  input  logic [WORD_W-1:0]     rn_val_in,
  input  logic [WORD_W-1:0]     rm_val_in,
  input  logic                  imm_in,
  input  logic [11:0]           shift_operand_in,
  input  logic [23:0]           signed_imm_24_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [REG_ADDR_W-1:0] src1_in,
  input  logic [REG_ADDR_W-1:0] src2_in,
  input  logic [3:0]            sr_in,
  output logic                  valid_out,
  output logic [WORD_W-1:0]     pc_out,
  output logic [CMD_W-1:0]      exe_cmd_out,
  output logic                  wb_en_out,
  output logic                  mem_r_en_out,
  output logic                  mem_w_en_out,
  output logic                  b_out,
  output logic                  s_out,
  output logic [WORD_W-1:0]     rn_val_out,
  output logic [WORD_W-1:0]     rm_val_out,
  output logic                  imm_out,
  output logic [11:0]           shift_operand_out,
  output logic [23:0]           signed_imm_24_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic [REG_ADDR_W-1:0] src1_out,
  output logic [REG_ADDR_W-1:0] src2_out,
  output logic [3:0]            sr_out,
  output logic                  select_out
);

  // NOTE: state uses <= so every flop samples pre-edge values; the missing final else
  // (freeze) is a plain hold on a clocked register, not a latch.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      // A flushed bubble is deliberately bit-identical to the reset state.
      valid_out         <= 1'b0;
      pc_out            <= '0;
      exe_cmd_out       <= '0;
      wb_en_out         <= 1'b0;
      mem_r_en_out      <= 1'b0;
      mem_w_en_out      <= 1'b0;
      b_out             <= 1'b0;
      s_out             <= 1'b0;
      rn_val_out        <= '0;
      rm_val_out        <= '0;
      imm_out           <= 1'b0;
      shift_operand_out <= '0;
      signed_imm_24_out <= '0;
      dest_out          <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
      sr_out            <= '0;
      select_out        <= 1'b0;
    end else if (!freeze) begin
      valid_out         <= id_valid;
      pc_out            <= pc_in;
      exe_cmd_out       <= exe_cmd_in;
      // Controls are gated by id_valid so a bubble can never write or branch.
      wb_en_out         <= id_valid & wb_en_in;
      mem_r_en_out      <= id_valid & mem_r_en_in;
      mem_w_en_out      <= id_valid & mem_w_en_in;
      b_out             <= id_valid & b_in;
      s_out             <= id_valid & s_in;
      select_out        <= id_valid & (mem_r_en_in | mem_w_en_in);
      rn_val_out        <= rn_val_in;
      rm_val_out        <= rm_val_in;
      imm_out           <= imm_in;
      shift_operand_out <= shift_operand_in;
      signed_imm_24_out <= signed_imm_24_in;
      dest_out          <= dest_in;
      src1_out          <= src1_in;
      src2_out          <= src2_in;
      sr_out            <= sr_in;
    end
  end

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Scoreboard bench for id_exe_stage_reg: the driver pushes expected outputs per edge,
// an independent monitor pops and compares them after each rising edge.
module tb_id_exe_stage_reg;

  typedef struct packed {
    logic        rst, flush, freeze, idv;
    logic [31:0] pc;
    logic [3:0]  cmd;
    logic        wb, mr, mw, b, s;
    logic [31:0] rn, rm;
    logic        imm;
    logic [11:0] so;
    logic [23:0] si;
    logic [3:0]  dest, src1, src2, sr;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  cmd;
    logic        wb, mr, mw, b, s, sel;
    logic [31:0] rn, rm;
    logic        imm;
    logic [11:0] so;
    logic [23:0] si;
    logic [3:0]  dest, src1, src2, sr;
  } out_t;

  typedef struct packed {
    logic        valid, sel;
    logic [31:0] pc;
  } hand_t;

  logic clk = 1'b0;
  in_t  drv;
  out_t dut_o;
  out_t model;
  out_t exp_q[$];
  hand_t hand_q[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_exe_stage_reg dut (
    .clk(clk), .rst(drv.rst), .freeze(drv.freeze), .flush(drv.flush), .id_valid(drv.idv),
    .pc_in(drv.pc), .exe_cmd_in(drv.cmd), .wb_en_in(drv.wb), .mem_r_en_in(drv.mr),
    .mem_w_en_in(drv.mw), .b_in(drv.b), .s_in(drv.s), .rn_val_in(drv.rn), .rm_val_in(drv.rm),
    .imm_in(drv.imm), .shift_operand_in(drv.so), .signed_imm_24_in(drv.si),
    .dest_in(drv.dest), .src1_in(drv.src1), .src2_in(drv.src2), .sr_in(drv.sr),
    .valid_out(dut_o.valid), .pc_out(dut_o.pc), .exe_cmd_out(dut_o.cmd),
    .wb_en_out(dut_o.wb), .mem_r_en_out(dut_o.mr), .mem_w_en_out(dut_o.mw),
    .b_out(dut_o.b), .s_out(dut_o.s), .rn_val_out(dut_o.rn), .rm_val_out(dut_o.rm),
    .imm_out(dut_o.imm), .shift_operand_out(dut_o.so), .signed_imm_24_out(dut_o.si),
    .dest_out(dut_o.dest), .src1_out(dut_o.src1), .src2_out(dut_o.src2), .sr_out(dut_o.sr),
    .select_out(dut_o.sel)
  );

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic out_t next_state(input out_t cur, input in_t v);
    out_t n;
    if (v.rst || v.flush) return '0;
    if (v.freeze) return cur;
    n.valid = v.idv;
    n.pc = v.pc;  n.cmd = v.cmd;
    n.wb = v.idv & v.wb;  n.mr = v.idv & v.mr;  n.mw = v.idv & v.mw;
    n.b = v.idv & v.b;    n.s = v.idv & v.s;    n.sel = v.idv & (v.mr | v.mw);
    n.rn = v.rn;  n.rm = v.rm;  n.imm = v.imm;  n.so = v.so;  n.si = v.si;
    n.dest = v.dest;  n.src1 = v.src1;  n.src2 = v.src2;  n.sr = v.sr;
    return n;
  endfunction

  // Apply one vector for the next edge; hand values are independent of the model.
  task automatic step(input in_t v, input logic hv, input logic hs, input logic [31:0] hpc);
    hand_t h;
    @(negedge clk);
    drv = v;
    model = next_state(model, v);
    exp_q.push_back(model);
    h.valid = hv;  h.sel = hs;  h.pc = hpc;
    hand_q.push_back(h);
  endtask

  // Monitor: one output word per rising edge while expectations are pending.
  initial begin
    out_t e;
    hand_t h;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        h = hand_q.pop_front();
        check("all_outputs", {32'b0, dut_o}, {32'b0, e});
        check("valid_hand", {191'b0, dut_o.valid}, {191'b0, h.valid});
        check("select_hand", {191'b0, dut_o.sel}, {191'b0, h.sel});
        check("pc_hand", {160'b0, dut_o.pc}, {160'b0, h.pc});
        check("ctrl_invariant", {191'b0, (!dut_o.valid && (dut_o.wb | dut_o.mr | dut_o.mw | dut_o.b | dut_o.s | dut_o.sel))}, 192'b0);
      end
    end
  end

  initial begin
    in_t v;
    model = '0;
    drv = '0;

    // Reset with every input driven high
    v = '1;
    step(v, 1'b0, 1'b0, 32'h0);
    step(v, 1'b0, 1'b0, 32'h0);

    // Plain load
    v = '0;
    v.idv = 1'b1;  v.cmd = 4'b0010;  v.wb = 1'b1;  v.rn = 32'h0000_0005;
    v.rm = 32'h8000_0001;  v.so = 12'h0C3;  v.dest = 4'd3;
    step(v, 1'b1, 1'b0, 32'h0);

    // Memory select via read, then via write
    v.wb = 1'b0;  v.mr = 1'b1;  v.so = 12'hFFF;
    step(v, 1'b1, 1'b1, 32'h0);
    v.mr = 1'b0;  v.mw = 1'b1;  v.src1 = 4'd9;  v.src2 = 4'd14;  v.sr = 4'b1010;
    v.si = 24'h80_0001;  v.imm = 1'b1;  v.s = 1'b1;
    step(v, 1'b1, 1'b1, 32'h0);

    // Freeze holds across changing inputs
    v = '0;
    v.idv = 1'b1;  v.wb = 1'b1;  v.pc = 32'h0000_0010;
    step(v, 1'b1, 1'b0, 32'h0000_0010);
    v.freeze = 1'b1;  v.pc = 32'h0000_0020;  v.mr = 1'b1;  v.idv = 1'b0;
    for (int i = 0; i < 3; i++) step(v, 1'b1, 1'b0, 32'h0000_0010);
    v.freeze = 1'b0;  v.mr = 1'b0;  v.idv = 1'b1;
    step(v, 1'b1, 1'b0, 32'h0000_0020);

    // Flush wins over freeze
    v.flush = 1'b1;  v.freeze = 1'b1;
    step(v, 1'b0, 1'b0, 32'h0);

    // Bubble from ID: controls suppressed, datapath still loads
    v = '0;
    v.wb = 1'b1;  v.mw = 1'b1;  v.b = 1'b1;  v.s = 1'b1;
    v.rm = 32'hDEAD_BEEF;  v.pc = 32'h0000_0044;
    step(v, 1'b0, 1'b0, 32'h0000_0044);

    // Branch load, then reset while frozen clears it
    v = '0;
    v.idv = 1'b1;  v.b = 1'b1;  v.si = 24'hFF_FFFE;  v.pc = 32'h0000_0100;  v.sr = 4'b0110;
    step(v, 1'b1, 1'b0, 32'h0000_0100);
    v.freeze = 1'b1;  v.rst = 1'b1;
    step(v, 1'b0, 1'b0, 32'h0);

    // Flush alone, then a final load
    v = '0;
    v.idv = 1'b1;  v.mr = 1'b1;  v.pc = 32'h0000_0200;  v.rn = 32'h1234_5678;
    step(v, 1'b1, 1'b1, 32'h0000_0200);
    v.flush = 1'b1;
    step(v, 1'b0, 1'b0, 32'h0);
    v.flush = 1'b0;  v.pc = 32'hFFFF_FFFC;  v.cmd = 4'b1001;
    step(v, 1'b1, 1'b1, 32'hFFFF_FFFC);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
